ddr_tile_reader: RTL and testbench
==================================

Name: ddr_tile_reader

Overview:
- AXI4 read-burst engine that fetches a 2D tile (N lines × M bus words, fixed byte stride between lines) from DDR.
- Streams the words in order to a valid/ready consumer: the Versat external-memory read port.
- Sits between the system AXI master interconnect (DDR / axi_ram model) and the accelerator datapath.
- A local FIFO absorbs burst data, so a burst is only requested when it is guaranteed to fit.

Parameters:
- ADDR_W, 30, AXI byte-address width (matches DDR_ADDR_W).
- DATA_W, 256, AXI/stream data width (matches MIG_BUS_W); power of two ≥ 32.
- MAX_BURST, 16, maximum beats per AR request; power of two, ≤ 256.
- FIFO_AW, 5, log2 FIFO depth; 2**FIFO_AW ≥ MAX_BURST.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cfg_addr  in  ADDR_W  tile base byte address, DATA_W/8 aligned
- cfg_stride  in  ADDR_W  byte distance between line starts, DATA_W/8 aligned
- cfg_len  in  16  words per line
- cfg_lines  in  16  number of lines
- start  in  1  one-cycle pulse; cfg_* sampled here
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after the last word is accepted by the consumer
- m_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos  out  1/ADDR_W/8/3/2/1/4/3/4  AXI read address
- m_axi_arvalid  out  1;  m_axi_arready  in  1
- m_axi_rid/rdata/rresp/rlast/rvalid  in  1/DATA_W/2/1/1;  m_axi_rready  out  1
- out_data  out  DATA_W;  out_valid  out  1;  out_ready  in  1
- err  out  1  sticky read-error flag (see Optional Feature)

Behaviour:
- Reset: state IDLE; busy, done, m_axi_arvalid, out_valid, err = 0; FIFO empty; all counters = 0.
- Constant AR fields: arid = 0, arsize = log2(DATA_W/8), arburst = INCR (2'b01), arlock = 0, arcache = 4'b0011, arprot = 0, arqos = 0.
- m_axi_rready = FIFO not full (never deasserted mid-burst, by the credit rule below).
- FSM states: IDLE, CALC, ADDR, DATA, DRAIN.
  - IDLE: on start with cfg_len ≠ 0 and cfg_lines ≠ 0, latch cfg, set line_addr = cur_addr = cfg_addr, words_left = cfg_len, lines_left = cfg_lines, busy = 1, go to CALC. start with a zero len or zero lines pulses done on the next cycle, busy stays 0. start while busy is ignored.
  - CALC (1 cycle): blen = min(words_left, MAX_BURST, words to the next 4 KB boundary from cur_addr). Go to ADDR when FIFO free slots (including reserved beats) ≥ blen, else stay in CALC.
  - ADDR: arvalid = 1, araddr = cur_addr, arlen = blen-1; hold stable until arready. On handshake go to DATA.
  - DATA: push each R beat into the FIFO. On the beat with rlast:
    - cur_addr += blen·DATA_W/8; words_left -= blen.
    - If words_left reaches 0: lines_left -= 1, line_addr += cfg_stride, cur_addr = new line_addr, words_left = cfg_len.
    - Go to CALC if lines_left ≠ 0, else DRAIN.
  - DRAIN: wait for FIFO empty, then pulse done, clear busy, go to IDLE.
- Exactly one outstanding AR at a time.
- Beats arriving before the expected rlast count, or extra beats, are still pushed; rlast is authoritative.
- Output stream: out_valid = FIFO not empty; word popped on out_valid & out_ready. FIFO is first-word-fall-through, so words appear 1 cycle after the R beat.
- A simultaneous push and pop on a full FIFO is legal.
- Address arithmetic wraps modulo 2**ADDR_W; no overflow flag.
- rst mid-transfer: everything returns to reset values next cycle. An AXI burst in flight is abandoned; the system resets the slave together with this block.

Optional Feature:
- Macro: DDR_TILE_READER_ERR_EN.
- Defined: any R beat with rresp[1] = 1 (SLVERR/DECERR) sets err. err stays set until the next accepted start or rst. Data is still forwarded and the transfer completes normally.
- Undefined: err tied to 0 and rresp ignored.

Decomposition:
- Package/header ddr_tile_reader.vh holds:
  - AXI_BURST_INCR, AXI_CACHE_DEFAULT
  - state encodings
  - the 4 KB boundary constant (12)
  - the ARSIZE function of DATA_W
- One sub-module: ddr_tile_fifo, a synchronous FWFT FIFO (DATA_W × 2**FIFO_AW) with full, empty and level outputs. The level output is used for the credit check in CALC.

Test Plan:
- Base 0x1000, stride 0x2000, len 8, lines 3, out_ready = 1: 3 AR requests (addr 0x1000/0x3000/0x5000, arlen 7), 24 words in DDR order, one done pulse.
- len 40, MAX_BURST 16, lines 1: arlen sequence 15, 15, 7 at 0x0, 0x200, 0x400 (DATA_W = 256).
- Base 0xFC0, len 8, DATA_W 256: 4 KB split into arlen 1 at 0xFC0 then arlen 5 at 0x1000.
- out_ready held low for 200 cycles with len 64: at most 2**FIFO_AW words buffered, rready never drops mid-burst, no data loss or reorder once out_ready is released.
- rst asserted during the second burst: next cycle busy = 0, arvalid = 0, out_valid = 0. A new start afterwards completes correctly.
- DDR_TILE_READER_ERR_EN with rresp = 2'b10 on beat 3: err rises on that beat and done still pulses. With the macro undefined, err stays 0.

Source files
------------

// File: rtl/ddr_tile_reader_pkg.sv
// Shared constants, FSM encoding and AXI helpers for the DDR tile reader.
package ddr_tile_reader_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;

  // AXI bursts must not cross a 4 KB boundary.
  localparam int unsigned BOUNDARY_LOG2 = 12;

  typedef enum logic [2:0] {
    StIdle,
    StCalc,
    StAddr,
    StData,
    StDrain
  } state_e;

  // ARSIZE encoding for a full-width beat of data_w bits.
  function automatic logic [2:0] axi_size(input int unsigned data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/ddr_tile_fifo.sv
// Synchronous first-word-fall-through FIFO with full/empty flags and fill level.
module ddr_tile_fifo #(
  parameter int unsigned DATA_W = 256,
  parameter int unsigned AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam int unsigned DEPTH = 2 ** AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       level_q;
  logic              do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));
  assign level = level_q;
  assign rdata = mem[rd_ptr_q];

  // A push into a full FIFO is fine when a pop frees a slot in the same cycle.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= wdata;
    end
  end

  // Pointers and fill level.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ddr_tile_reader.sv
// AXI4 read-burst engine fetching an N-line x M-word strided tile into a
// valid/ready stream. Optional read-error flag: define DDR_TILE_READER_ERR_EN.
module ddr_tile_reader
  import ddr_tile_reader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 256,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned FIFO_AW   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [ADDR_W-1:0] cfg_stride,
  input  logic [15:0]       cfg_len,
  input  logic [15:0]       cfg_lines,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              m_axi_arid,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arlock,
  output logic [3:0]        m_axi_arcache,
  output logic [2:0]        m_axi_arprot,
  output logic [3:0]        m_axi_arqos,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic              m_axi_rid,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              err
);

  localparam int unsigned BYTE_SH = $clog2(DATA_W / 8);
  localparam int unsigned DEPTH   = 2 ** FIFO_AW;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] line_addr_q, line_addr_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [15:0]       words_left_q, words_left_d;
  logic [15:0]       lines_left_q, lines_left_d;
  logic [15:0]       len_q, len_d;
  logic [8:0]        blen_q, blen_d;
  logic              done_q, done_d;
  logic              err_clr;

  logic              fifo_full, fifo_empty, fifo_push;
  logic [FIFO_AW:0]  fifo_level;
  logic              r_fire;

  logic [BOUNDARY_LOG2:0] bnd_bytes;
  logic [16:0]            bnd_words;
  logic [16:0]            blen_c;
  logic [FIFO_AW:0]       free_c;
  logic [15:0]            wl_next;
  logic [ADDR_W-1:0]      burst_bytes;
  logic [ADDR_W-1:0]      next_line;

  // Constant AR attributes.
  assign m_axi_arid    = 1'b0;
  assign m_axi_arsize  = axi_size(DATA_W);
  assign m_axi_arburst = AXI_BURST_INCR;
  assign m_axi_arlock  = 1'b0;
  assign m_axi_arcache = AXI_CACHE_DEFAULT;
  assign m_axi_arprot  = 3'b000;
  assign m_axi_arqos   = 4'b0000;

  assign m_axi_araddr  = cur_addr_q;
  assign m_axi_arlen   = 8'(blen_q - 9'd1);
  assign m_axi_arvalid = (state_q == StAddr);

  // The credit check in CALC guarantees a whole burst fits, so rready only
  // drops once the FIFO is full between bursts.
  assign m_axi_rready = ~fifo_full;
  assign r_fire       = m_axi_rvalid & m_axi_rready;
  assign fifo_push    = r_fire & (state_q == StData);

  assign busy = (state_q != StIdle);
  assign done = done_q;

  ddr_tile_fifo #(
    .DATA_W (DATA_W),
    .AW     (FIFO_AW)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (m_axi_rdata),
    .pop   (out_ready),
    .rdata (out_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign out_valid = ~fifo_empty;

  // Burst length: limited by remaining words, MAX_BURST and the next 4 KB boundary.
  always_comb begin
    bnd_bytes = (BOUNDARY_LOG2+1)'(2 ** BOUNDARY_LOG2)
              - {1'b0, cur_addr_q[BOUNDARY_LOG2-1:0]};
    bnd_words = 17'(bnd_bytes >> BYTE_SH);
    blen_c    = {1'b0, words_left_q};
    if (blen_c > 17'(MAX_BURST)) blen_c = 17'(MAX_BURST);
    if (blen_c > bnd_words)      blen_c = bnd_words;
    // Only one AR is ever outstanding, so no beats are in flight during CALC.
    free_c      = (FIFO_AW+1)'(DEPTH) - fifo_level;
    wl_next     = words_left_q - 16'(blen_q);
    burst_bytes = ADDR_W'(blen_q) << BYTE_SH;
    next_line   = line_addr_q + stride_q;
  end

  // Next-state logic for the transfer FSM and its counters.
  always_comb begin
    state_d      = state_q;
    line_addr_d  = line_addr_q;
    cur_addr_d   = cur_addr_q;
    stride_d     = stride_q;
    words_left_d = words_left_q;
    lines_left_d = lines_left_q;
    len_d        = len_q;
    blen_d       = blen_q;
    done_d       = 1'b0;
    err_clr      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (cfg_len != 16'd0 && cfg_lines != 16'd0) begin
            line_addr_d  = cfg_addr;
            cur_addr_d   = cfg_addr;
            stride_d     = cfg_stride;
            words_left_d = cfg_len;
            lines_left_d = cfg_lines;
            len_d        = cfg_len;
            err_clr      = 1'b1;
            state_d      = StCalc;
          end else begin
            // Empty tile: acknowledge without touching the bus.
            done_d = 1'b1;
          end
        end
      end
      StCalc: begin
        blen_d = 9'(blen_c);
        if (17'(free_c) >= blen_c) state_d = StAddr;
      end
      StAddr: begin
        if (m_axi_arready) state_d = StData;
      end
      StData: begin
        if (r_fire && m_axi_rlast) begin
          if (wl_next == 16'd0) begin
            lines_left_d = lines_left_q - 16'd1;
            line_addr_d  = next_line;
            cur_addr_d   = next_line;
            words_left_d = len_q;
            state_d      = (lines_left_q == 16'd1) ? StDrain : StCalc;
          end else begin
            cur_addr_d   = cur_addr_q + burst_bytes;
            words_left_d = wl_next;
            state_d      = StCalc;
          end
        end
      end
      StDrain: begin
        if (fifo_empty) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      line_addr_q  <= '0;
      cur_addr_q   <= '0;
      stride_q     <= '0;
      words_left_q <= '0;
      lines_left_q <= '0;
      len_q        <= '0;
      blen_q       <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      line_addr_q  <= line_addr_d;
      cur_addr_q   <= cur_addr_d;
      stride_q     <= stride_d;
      words_left_q <= words_left_d;
      lines_left_q <= lines_left_d;
      len_q        <= len_d;
      blen_q       <= blen_d;
      done_q       <= done_d;
    end
  end

`ifdef DDR_TILE_READER_ERR_EN
  logic err_q;

  // Sticky flag for SLVERR/DECERR beats, cleared by the next accepted start.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_clr) begin
      err_q <= 1'b0;
    end else if (fifo_push && m_axi_rresp[1]) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;

  logic unused_resp;
  assign unused_resp = m_axi_rresp[0];
`else
  assign err = 1'b0;

  logic unused_resp;
  assign unused_resp = ^{err_clr, m_axi_rresp};
`endif

  logic unused_rid;
  assign unused_rid = m_axi_rid;

endmodule

// File: tb/tb_ddr_tile_reader.sv
// Directed bench for ddr_tile_reader with a behavioural AXI read slave.
module tb_ddr_tile_reader;

  localparam int unsigned AW = 30;
  localparam int unsigned DW = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_addr, cfg_stride;
  logic [15:0]   cfg_len, cfg_lines;
  logic          start, busy, done;
  logic          arid, arlock, arvalid, arready;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, rresp;
  logic [3:0]    arcache, arqos;
  logic          rid, rlast, rvalid, rready;
  logic [DW-1:0] rdata, out_data;
  logic          out_valid, out_ready, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ddr_tile_reader dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_addr      (cfg_addr),
    .cfg_stride    (cfg_stride),
    .cfg_len       (cfg_len),
    .cfg_lines     (cfg_lines),
    .start         (start),
    .busy          (busy),
    .done          (done),
    .m_axi_arid    (arid),
    .m_axi_araddr  (araddr),
    .m_axi_arlen   (arlen),
    .m_axi_arsize  (arsize),
    .m_axi_arburst (arburst),
    .m_axi_arlock  (arlock),
    .m_axi_arcache (arcache),
    .m_axi_arprot  (arprot),
    .m_axi_arqos   (arqos),
    .m_axi_arvalid (arvalid),
    .m_axi_arready (arready),
    .m_axi_rid     (rid),
    .m_axi_rdata   (rdata),
    .m_axi_rresp   (rresp),
    .m_axi_rlast   (rlast),
    .m_axi_rvalid  (rvalid),
    .m_axi_rready  (rready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .err           (err)
  );

  // DDR content: each word is tagged with its own byte address.
  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {8{2'b10, a}};
  endfunction

  // AXI read slave: one burst at a time, one beat per cycle.
  logic [AW-1:0] s_addr;
  logic [7:0]    s_len, s_beat;
  logic          s_active;
  logic          inject_err;

  always @(posedge clk) begin
    if (rst) begin
      arready  <= 1'b0;
      rvalid   <= 1'b0;
      rlast    <= 1'b0;
      rresp    <= 2'b00;
      rdata    <= '0;
      s_active <= 1'b0;
      s_beat   <= 8'd0;
    end else if (!s_active) begin
      arready <= 1'b1;
      if (arvalid && arready) begin
        arready  <= 1'b0;
        s_active <= 1'b1;
        s_addr   <= araddr;
        s_len    <= arlen;
        s_beat   <= 8'd0;
        rvalid   <= 1'b1;
        rdata    <= mem_word(araddr);
        rlast    <= (arlen == 8'd0);
        rresp    <= 2'b00;
      end
    end else if (rvalid && rready) begin
      if (rlast) begin
        rvalid   <= 1'b0;
        rlast    <= 1'b0;
        rresp    <= 2'b00;
        s_active <= 1'b0;
      end else begin
        s_beat <= s_beat + 8'd1;
        rdata  <= mem_word(s_addr + AW'({s_beat + 8'd1, 5'b00000}));
        rlast  <= ((s_beat + 8'd1) == s_len);
        rresp  <= (inject_err && (s_beat + 8'd1) == 8'd3) ? 2'b10 : 2'b00;
      end
    end
  end

  // Passive monitor, sampling on the falling edge.
  logic [AW-1:0]  ar_addr_q[$];
  logic [7:0]     ar_len_q[$];
  logic [DW-1:0]  got[$];
  int done_cnt = 0;
  int occ = 0;
  int max_occ = 0;
  int rdrop = 0;

  always @(negedge clk) begin
    if (rst) begin
      occ = 0;
    end else begin
      if (arvalid && arready) begin
        ar_addr_q.push_back(araddr);
        ar_len_q.push_back(arlen);
      end
      if (rvalid && rready) occ++;
      if (rvalid && !rready) rdrop++;
      if (out_valid && out_ready) begin
        got.push_back(out_data);
        occ--;
      end
      if (occ > max_occ) max_occ = occ;
      if (done) done_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    ar_addr_q.delete();
    ar_len_q.delete();
    got.delete();
    max_occ = 0;
    rdrop   = 0;
  endtask

  task automatic do_start(input logic [AW-1:0] a, input logic [AW-1:0] s,
                          input logic [15:0] len, input logic [15:0] lines);
    @(negedge clk);
    cfg_addr   = a;
    cfg_stride = s;
    cfg_len    = len;
    cfg_lines  = lines;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic chk_ar(input string tag, input int idx,
                        input logic [AW-1:0] a, input logic [7:0] l);
    if (idx < ar_addr_q.size()) begin
      chk({tag, "_addr"}, 64'(ar_addr_q[idx]), 64'(a));
      chk({tag, "_len"}, 64'(ar_len_q[idx]), 64'(l));
    end else begin
      chk({tag, "_missing"}, 64'(ar_addr_q.size()), 64'(idx + 1));
    end
  endtask

  task automatic chk_words(input string tag, input logic [AW-1:0] base,
                           input logic [AW-1:0] stride, input int len, input int lines);
    int k = 0;
    chk({tag, "_count"}, 64'(got.size()), 64'(len * lines));
    for (int l = 0; l < lines; l++) begin
      for (int w = 0; w < len; w++) begin
        if (k < got.size())
          chk_word({tag, "_data"}, got[k], mem_word(base + AW'(l) * stride + AW'(w * 32)));
        k++;
      end
    end
  endtask

  logic exp_err;
  int   dc0;

  initial begin
`ifdef DDR_TILE_READER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; inject_err = 1'b0; rid = 1'b0;
    cfg_addr = '0; cfg_stride = '0; cfg_len = '0; cfg_lines = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state and constant AR attributes.
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_rready", 64'(rready), 64'd1);
    chk("ar_const", 64'({arid, arsize, arburst, arlock, arcache, arprot, arqos}),
        64'({1'b0, 3'd5, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0}));

    // Zero-length tile: done next cycle, never busy.
    clear_logs();
    do_start(30'h1000, 30'h0, 16'd0, 16'd3);
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_no_ar", 64'(ar_addr_q.size()), 64'd0);

    // 3 lines x 8 words, stride 0x2000.
    clear_logs();
    dc0 = done_cnt;
    do_start(30'h1000, 30'h2000, 16'd8, 16'd3);
    chk("t1_busy", 64'(busy), 64'd1);
    wait_done("t1_done", 500);
    repeat (3) @(negedge clk);
    chk("t1_done_cnt", 64'(done_cnt - dc0), 64'd1);
    chk("t1_busy_end", 64'(busy), 64'd0);
    chk("t1_nar", 64'(ar_addr_q.size()), 64'd3);
    chk_ar("t1_ar0", 0, 30'h1000, 8'd7);
    chk_ar("t1_ar1", 1, 30'h3000, 8'd7);
    chk_ar("t1_ar2", 2, 30'h5000, 8'd7);
    chk_words("t1", 30'h1000, 30'h2000, 8, 3);

    // 40 words split by MAX_BURST.
    clear_logs();
    do_start(30'h0, 30'h0, 16'd40, 16'd1);
    wait_done("t2_done", 500);
    repeat (2) @(negedge clk);
    chk("t2_nar", 64'(ar_addr_q.size()), 64'd3);
    chk_ar("t2_ar0", 0, 30'h000, 8'd15);
    chk_ar("t2_ar1", 1, 30'h200, 8'd15);
    chk_ar("t2_ar2", 2, 30'h400, 8'd7);
    chk_words("t2", 30'h0, 30'h0, 40, 1);

    // 4 KB boundary split.
    clear_logs();
    do_start(30'hFC0, 30'h0, 16'd8, 16'd1);
    wait_done("t3_done", 500);
    repeat (2) @(negedge clk);
    chk("t3_nar", 64'(ar_addr_q.size()), 64'd2);
    chk_ar("t3_ar0", 0, 30'hFC0, 8'd1);
    chk_ar("t3_ar1", 1, 30'h1000, 8'd5);
    chk_words("t3", 30'hFC0, 30'h0, 8, 1);

    // Back-pressure: consumer stalled for 200 cycles.
    clear_logs();
    out_ready = 1'b0;
    do_start(30'h8000, 30'h0, 16'd64, 16'd1);
    repeat (200) @(negedge clk);
    chk("t4_buffered", 64'(occ), 64'd32);
    chk("t4_nar_stalled", 64'(ar_addr_q.size()), 64'd2);
    chk("t4_busy", 64'(busy), 64'd1);
    out_ready = 1'b1;
    wait_done("t4_done", 1000);
    repeat (2) @(negedge clk);
    chk("t4_max_occ", 64'(max_occ), 64'd32);
    chk("t4_rdrop", 64'(rdrop), 64'd0);
    chk("t4_nar", 64'(ar_addr_q.size()), 64'd4);
    chk_words("t4", 30'h8000, 30'h0, 64, 1);

    // Reset during the second burst, then a fresh transfer.
    clear_logs();
    do_start(30'h1000, 30'h2000, 16'd8, 16'd3);
    for (int n = 0; n < 200 && ar_addr_q.size() < 2; n++) @(negedge clk);
    chk("t5_second_ar", 64'(ar_addr_q.size()), 64'd2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    chk("t5_rst_arvalid", 64'(arvalid), 64'd0);
    chk("t5_rst_out_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    do_start(30'h4000, 30'h100, 16'd4, 16'd2);
    wait_done("t5_done", 500);
    repeat (2) @(negedge clk);
    chk_ar("t5_ar0", 0, 30'h4000, 8'd3);
    chk_ar("t5_ar1", 1, 30'h4100, 8'd3);
    chk_words("t5", 30'h4000, 30'h100, 4, 2);

    // Error response on beat 3; transfer must still complete.
    clear_logs();
    inject_err = 1'b1;
    dc0 = done_cnt;
    do_start(30'h2000, 30'h0, 16'd8, 16'd1);
    chk("t6_err_clear", 64'(err), 64'd0);
    wait_done("t6_done", 500);
    repeat (2) @(negedge clk);
    inject_err = 1'b0;
    chk("t6_done_cnt", 64'(done_cnt - dc0), 64'd1);
    chk("t6_err", 64'(err), 64'(exp_err));
    chk_words("t6", 30'h2000, 30'h0, 8, 1);
    clear_logs();
    do_start(30'h2000, 30'h0, 16'd2, 16'd1);
    chk("t6_err_cleared", 64'(err), 64'd0);
    wait_done("t6b_done", 500);
    repeat (2) @(negedge clk);
    chk("t6_err_stays_low", 64'(err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
